// File: rtl/dmem_lane_array.sv
// Byte-lane data memory behind the MEM stage: store byte masks, load extraction
// with sign/zero extension, misalignment flags, and write-first same-word bypass.
module dmem_lane_array #(
  parameter int    ADDR_WIDTH = 10,
  parameter int    LANES      = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [ADDR_WIDTH-1:0] W_ADDR,
  input  logic [2:0]            W_FUNCT3,
  input  logic                  WRITE_EN,
  input  logic [8*LANES-1:0]    DIN,
  input  logic [ADDR_WIDTH-1:0] R_ADDR,
  input  logic [2:0]            R_FUNCT3,
  input  logic                  READ_EN,
  output logic [8*LANES-1:0]    DOUT,
  output logic                  READ_VALID,
  output logic                  LOAD_MISALIGNED,
  output logic                  STORE_MISALIGNED
);
  localparam int W     = 8 * LANES;
  localparam int OFFW  = $clog2(LANES);
  localparam int IDXW  = ADDR_WIDTH - OFFW;
  localparam int DEPTH = 1 << IDXW;

  function automatic logic aligned(input logic [OFFW-1:0] off, input logic [1:0] slog);
    logic [2:0] o;
    o = 3'(off);
    case (slog)
      2'd0:    return 1'b1;
      2'd1:    return o[0] == 1'b0;
      2'd2:    return o[1:0] == 2'd0;
      default: return o == 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] span(input logic [1:0] slog);
    case (slog)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  logic [IDXW-1:0]  w_idx_s, r_idx_s;
  logic [OFFW-1:0]  w_off_s, r_off_s;
  logic             store_ok_s, load_ok_s, w_fire_s, r_fire_s, same_word_s;
  logic [LANES-1:0] wmask_s;
  logic [W-1:0]     wdata_s;

  assign w_idx_s     = W_ADDR[ADDR_WIDTH-1:OFFW];
  assign w_off_s     = W_ADDR[OFFW-1:0];
  assign r_idx_s     = R_ADDR[ADDR_WIDTH-1:OFFW];
  assign r_off_s     = R_ADDR[OFFW-1:0];
  // Illegal encodings fold into the misaligned path.
  assign store_ok_s  = !W_FUNCT3[2] && ((W_FUNCT3[1:0] != 2'b11) || (LANES == 8)) &&
                       aligned(w_off_s, W_FUNCT3[1:0]);
  assign load_ok_s   = (R_FUNCT3 != 3'b111) &&
                       ((LANES == 8) || ((R_FUNCT3 != 3'b011) && (R_FUNCT3 != 3'b110))) &&
                       aligned(r_off_s, R_FUNCT3[1:0]);
  assign w_fire_s    = WRITE_EN && RSTN && store_ok_s;
  assign r_fire_s    = READ_EN && load_ok_s;
  assign wmask_s     = LANES'(span(W_FUNCT3[1:0]) << w_off_s);
  assign wdata_s     = DIN << {w_off_s, 3'b000};
  assign same_word_s = (w_idx_s == r_idx_s);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     rdata_q, fwd_data_q;
  logic [LANES-1:0] fwd_mask_q;
  logic [OFFW-1:0]  off_q;
  logic [2:0]       f3_q;
  logic             data_ok_q, read_valid_q, load_mis_q, store_mis_q;

  // Byte-lane writes; lanes outside the mask keep their contents.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < LANES; k++) begin
      if (w_fire_s && wmask_s[k]) mem_q[w_idx_s][8*k +: 8] <= wdata_s[8*k +: 8];
    end
  end

  // Read-port register plus the bypass lanes of a same-cycle store to the same word.
  always_ff @(posedge CLK) begin
    if (r_fire_s) begin
      rdata_q    <= mem_q[r_idx_s];
      fwd_mask_q <= (w_fire_s && same_word_s) ? wmask_s : '0;
      fwd_data_q <= wdata_s;
    end
  end

  // Status flags and captured load shape; data_ok_q forces DOUT to zero out of reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      read_valid_q <= 1'b0;
      load_mis_q   <= 1'b0;
      store_mis_q  <= 1'b0;
      off_q        <= '0;
      f3_q         <= 3'b000;
      data_ok_q    <= 1'b0;
    end else begin
      read_valid_q <= READ_EN;
      load_mis_q   <= READ_EN && !load_ok_s;
      store_mis_q  <= WRITE_EN && !store_ok_s;
      if (r_fire_s) begin
        off_q     <= r_off_s;
        f3_q      <= R_FUNCT3;
        data_ok_q <= 1'b1;
      end
    end
  end

  logic [W-1:0] word_s, shifted_s, keep_s, dout_s;
  logic         sign_s;

  // Merge bypass lanes, align the fetched bytes to bit 0 and extend.
  always_comb begin
    word_s = '0;
    keep_s = '1;
    sign_s = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      word_s[8*k +: 8] = !data_ok_q ? 8'h00 :
                         (fwd_mask_q[k] ? fwd_data_q[8*k +: 8] : rdata_q[8*k +: 8]);
    end
    shifted_s = word_s >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'd0: begin keep_s = W'(8'hFF);         sign_s = shifted_s[7];  end
      2'd1: begin keep_s = W'(16'hFFFF);      sign_s = shifted_s[15]; end
      2'd2: begin keep_s = W'(32'hFFFF_FFFF); sign_s = shifted_s[31]; end
      default: begin keep_s = '1;             sign_s = 1'b0;          end
    endcase
    dout_s = (shifted_s & keep_s) | ((sign_s && !f3_q[2]) ? ~keep_s : '0);
  end

  assign DOUT             = dout_s;
  assign READ_VALID       = read_valid_q;
  assign LOAD_MISALIGNED  = load_mis_q;
  assign STORE_MISALIGNED = store_mis_q;
endmodule

// File: tb/tb_dmem_lane_array.sv
// Bench for dmem_lane_array: 4-lane and 8-lane instances checked against a
// byte-addressed reference memory model.
module tb_dmem_lane_array;
  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  w_addr4, r_addr4, w_addr8, r_addr8;
  logic [2:0]  wf3_4, rf3_4, wf3_8, rf3_8;
  logic        we4, re4, we8, re8;
  logic [31:0] din4, dout4;
  logic [63:0] din8, dout8;
  logic        rv4, lm4, sm4, rv8, lm8, sm8;

  int total = 0;
  int bad   = 0;

  bit [7:0]    m4 [1024];
  bit [7:0]    m8 [1024];
  logic [63:0] e_dout [2];
  bit          e_rv [2];
  bit          e_lm [2];
  bit          e_sm [2];

  always #5 clk = ~clk;

  dmem_lane_array #(.ADDR_WIDTH(10), .LANES(4)) dut4 (
    .CLK(clk), .RSTN(rstn), .W_ADDR(w_addr4), .W_FUNCT3(wf3_4), .WRITE_EN(we4), .DIN(din4),
    .R_ADDR(r_addr4), .R_FUNCT3(rf3_4), .READ_EN(re4), .DOUT(dout4), .READ_VALID(rv4),
    .LOAD_MISALIGNED(lm4), .STORE_MISALIGNED(sm4));

  dmem_lane_array #(.ADDR_WIDTH(10), .LANES(8)) dut8 (
    .CLK(clk), .RSTN(rstn), .W_ADDR(w_addr8), .W_FUNCT3(wf3_8), .WRITE_EN(we8), .DIN(din8),
    .R_ADDR(r_addr8), .R_FUNCT3(rf3_8), .READ_EN(re8), .DOUT(dout8), .READ_VALID(rv8),
    .LOAD_MISALIGNED(lm8), .STORE_MISALIGNED(sm8));

  // Reference model: a flat byte memory, RISC-V sizes and alignment rules.
  function automatic bit st_ok(int lanes, int a, logic [2:0] f3);
    int sz = 1 << f3[1:0];
    if (f3[2] || sz > lanes) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic bit ld_ok(int lanes, int a, logic [2:0] f3);
    int sz = 1 << f3[1:0];
    if (f3 == 3'b111 || sz > lanes) return 1'b0;
    if (lanes == 4 && f3 == 3'b110) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic void model_store(int d, int a, logic [2:0] f3, logic [63:0] din);
    int sz = 1 << f3[1:0];
    for (int i = 0; i < sz; i++) begin
      if (d == 0) m4[(a + i) % 1024] = din[8*i +: 8];
      else        m8[(a + i) % 1024] = din[8*i +: 8];
    end
  endfunction

  function automatic logic [63:0] ld_val(int d, int a, logic [2:0] f3);
    int sz = 1 << f3[1:0];
    logic [63:0] v = 64'd0;
    logic [63:0] b;
    for (int i = 0; i < sz; i++) begin
      b = {56'd0, (d == 0) ? m4[(a + i) % 1024] : m8[(a + i) % 1024]};
      v = v | (b << (8 * i));
    end
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    return v;
  endfunction

  task automatic idle();
    we4 = 1'b0; re4 = 1'b0; we8 = 1'b0; re8 = 1'b0;
  endtask

  task automatic clear_expect();
    for (int d = 0; d < 2; d++) begin
      e_dout[d] = 64'd0; e_rv[d] = 1'b0; e_lm[d] = 1'b0; e_sm[d] = 1'b0;
    end
  endtask

  // One clock edge, then advance the model with the inputs that were sampled.
  task automatic step();
    bit ok;
    @(posedge clk);
    #1;
    ok = st_ok(4, int'(w_addr4), wf3_4);
    if (we4 && ok) model_store(0, int'(w_addr4), wf3_4, {32'd0, din4});
    e_sm[0] = we4 && !ok;
    e_rv[0] = re4;
    e_lm[0] = re4 && !ld_ok(4, int'(r_addr4), rf3_4);
    if (re4 && !e_lm[0]) e_dout[0] = ld_val(0, int'(r_addr4), rf3_4);
    ok = st_ok(8, int'(w_addr8), wf3_8);
    if (we8 && ok) model_store(1, int'(w_addr8), wf3_8, din8);
    e_sm[1] = we8 && !ok;
    e_rv[1] = re8;
    e_lm[1] = re8 && !ld_ok(8, int'(r_addr8), rf3_8);
    if (re8 && !e_lm[1]) e_dout[1] = ld_val(1, int'(r_addr8), rf3_8);
  endtask

  task automatic st4(logic [2:0] f3, logic [9:0] a, logic [31:0] d);
    we4 = 1'b1; wf3_4 = f3; w_addr4 = a; din4 = d;
  endtask

  task automatic ld4(logic [2:0] f3, logic [9:0] a);
    re4 = 1'b1; rf3_4 = f3; r_addr4 = a;
  endtask

  function automatic logic [9:0] pick_addr();
    if ($urandom_range(0, 9) < 8) return 10'($urandom_range(0, 47));
    return 10'($urandom_range(0, 1023));
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    w_addr4 = 10'd0; r_addr4 = 10'd0; w_addr8 = 10'd0; r_addr8 = 10'd0;
    wf3_4 = 3'd0; rf3_4 = 3'd0; wf3_8 = 3'd0; rf3_8 = 3'd0;
    din4 = 32'd0; din8 = 64'd0;
    clear_expect();
    #12;
    total++; if (dout4 !== 32'd0) begin bad++; $display("FAIL reset_dout4 got=%h want=0", dout4); end
    total++; if ({rv4, lm4, sm4} !== 3'b000) begin bad++; $display("FAIL reset_flags4 got=%b want=000", {rv4, lm4, sm4}); end
    total++; if (dout8 !== 64'd0) begin bad++; $display("FAIL reset_dout8 got=%h want=0", dout8); end
    total++; if ({rv8, lm8, sm8} !== 3'b000) begin bad++; $display("FAIL reset_flags8 got=%b want=000", {rv8, lm8, sm8}); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 256; i++) begin
      st4(3'b010, 10'(i * 4), $urandom);
      we8 = (i < 128); wf3_8 = 3'b011; w_addr8 = 10'(i * 8); din8 = {$urandom, $urandom};
      step();
    end
    idle();
    total++; if (sm4 !== 1'b0 || sm8 !== 1'b0) begin bad++; $display("FAIL fill_sm got=%b%b want=00", sm4, sm8); end
  endtask

  task automatic test_word_rw();
    st4(3'b010, 10'h10, 32'hDEADBEEF); step(); idle();
    ld4(3'b010, 10'h10); step(); idle();
    total++; if (dout4 !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_word got=%h want=deadbeef", dout4); end
    total++; if (rv4 !== 1'b1) begin bad++; $display("FAIL lw_valid got=%b want=1", rv4); end
    step();
    total++; if (rv4 !== 1'b0 || dout4 !== 32'hDEADBEEF) begin bad++; $display("FAIL idle_hold got=%b/%h want=0/deadbeef", rv4, dout4); end
  endtask

  task automatic test_extract();
    logic [2:0]  f3s  [4];
    logic [9:0]  adrs [4];
    logic [31:0] exps [4];
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b101};
    adrs = '{10'h13, 10'h13, 10'h12, 10'h10};
    exps = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      ld4(f3s[i], adrs[i]); step(); idle();
      total++; if (dout4 !== exps[i]) begin bad++; $display("FAIL extract_%0d got=%h want=%h", i, dout4, exps[i]); end
    end
  endtask

  task automatic test_byte_store();
    st4(3'b000, 10'h11, 32'h00000055); step(); idle();
    ld4(3'b010, 10'h10); step(); idle();
    total++; if (dout4 !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_merge got=%h want=dead55ef", dout4); end
  endtask

  task automatic test_misaligned();
    st4(3'b001, 10'h11, 32'h0000FFFF); step(); idle();
    total++; if (sm4 !== 1'b1) begin bad++; $display("FAIL st_mis got=%b want=1", sm4); end
    ld4(3'b010, 10'h02); step(); idle();
    total++; if ({rv4, lm4, sm4} !== 3'b110) begin bad++; $display("FAIL ld_mis_flags got=%b want=110", {rv4, lm4, sm4}); end
    total++; if (dout4 !== 32'hDEAD55EF) begin bad++; $display("FAIL ld_mis_hold got=%h want=dead55ef", dout4); end
    ld4(3'b011, 10'h10); step(); idle();
    total++; if (lm4 !== 1'b1) begin bad++; $display("FAIL ld_illegal got=%b want=1", lm4); end
    ld4(3'b010, 10'h10); step(); idle();
    total++; if (dout4 !== 32'hDEAD55EF || lm4 !== 1'b0) begin bad++; $display("FAIL mis_unchanged got=%h/%b want=dead55ef/0", dout4, lm4); end
  endtask

  task automatic test_back_to_back();
    st4(3'b010, 10'h20, 32'hAAAAAAAA); step(); idle();
    st4(3'b001, 10'h20, 32'h00001234); ld4(3'b010, 10'h20); step(); idle();
    total++; if (dout4 !== 32'hAAAA1234) begin bad++; $display("FAIL fwd_same got=%h want=aaaa1234", dout4); end
    st4(3'b010, 10'h24, 32'h11223344); ld4(3'b010, 10'h20); step(); idle();
    total++; if (dout4 !== 32'hAAAA1234) begin bad++; $display("FAIL fwd_other got=%h want=aaaa1234", dout4); end
    ld4(3'b010, 10'h24); step(); idle();
    total++; if (dout4 !== 32'h11223344) begin bad++; $display("FAIL other_word got=%h want=11223344", dout4); end
  endtask

  task automatic test_reset_midload();
    ld4(3'b010, 10'h10); step();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    total++; if (dout4 !== 32'd0 || {rv4, lm4, sm4} !== 3'b000) begin bad++; $display("FAIL rst_async got=%h/%b want=0/000", dout4, {rv4, lm4, sm4}); end
    st4(3'b010, 10'h10, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    total++; if (dout4 !== 32'd0 || rv4 !== 1'b0) begin bad++; $display("FAIL rst_ignore got=%h/%b want=0/0", dout4, rv4); end
    @(negedge clk);
    rstn = 1'b1;
    idle();
    clear_expect();
    ld4(3'b010, 10'h10); step(); idle();
    total++; if (dout4 !== 32'hDEAD55EF) begin bad++; $display("FAIL post_reset got=%h want=dead55ef", dout4); end
  endtask

  task automatic test_lanes8();
    logic [2:0]  f3s  [4];
    logic [9:0]  adrs [4];
    logic [63:0] exps [4];
    f3s  = '{3'b110, 3'b010, 3'b011, 3'b101};
    adrs = '{10'h0C, 10'h08, 10'h08, 10'h0E};
    exps = '{64'h0000000001234567, 64'hFFFFFFFF89ABCDEF, 64'h0123456789ABCDEF, 64'h0000000000000123};
    we8 = 1'b1; wf3_8 = 3'b011; w_addr8 = 10'h08; din8 = 64'h0123456789ABCDEF; step(); idle();
    for (int i = 0; i < 4; i++) begin
      re8 = 1'b1; rf3_8 = f3s[i]; r_addr8 = adrs[i]; step(); idle();
      total++; if (dout8 !== exps[i]) begin bad++; $display("FAIL l8_%0d got=%h want=%h", i, dout8, exps[i]); end
    end
    we8 = 1'b1; wf3_8 = 3'b011; w_addr8 = 10'h04; step(); idle();
    total++; if (sm8 !== 1'b1) begin bad++; $display("FAIL sd_mis got=%b want=1", sm8); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      we4 = 1'($urandom_range(0, 1)); wf3_4 = 3'($urandom_range(0, 7)); w_addr4 = pick_addr(); din4 = $urandom;
      re4 = 1'($urandom_range(0, 1)); rf3_4 = 3'($urandom_range(0, 7)); r_addr4 = pick_addr();
      we8 = 1'($urandom_range(0, 1)); wf3_8 = 3'($urandom_range(0, 7)); w_addr8 = pick_addr(); din8 = {$urandom, $urandom};
      re8 = 1'($urandom_range(0, 1)); rf3_8 = 3'($urandom_range(0, 7)); r_addr8 = pick_addr();
      if ($urandom_range(0, 1) == 0) w_addr4 = w_addr4 & ~10'((1 << wf3_4[1:0]) - 1);
      if ($urandom_range(0, 1) == 0) r_addr4 = r_addr4 & ~10'((1 << rf3_4[1:0]) - 1);
      if ($urandom_range(0, 1) == 0) w_addr8 = w_addr8 & ~10'((1 << wf3_8[1:0]) - 1);
      if ($urandom_range(0, 1) == 0) r_addr8 = r_addr8 & ~10'((1 << rf3_8[1:0]) - 1);
      step();
      total++; if (dout4 !== e_dout[0][31:0]) begin bad++; $display("FAIL rnd4_dout n=%0d got=%h want=%h", n, dout4, e_dout[0][31:0]); end
      total++; if ({rv4, lm4, sm4} !== {e_rv[0], e_lm[0], e_sm[0]}) begin bad++; $display("FAIL rnd4_flags n=%0d got=%b want=%b", n, {rv4, lm4, sm4}, {e_rv[0], e_lm[0], e_sm[0]}); end
      total++; if (dout8 !== e_dout[1]) begin bad++; $display("FAIL rnd8_dout n=%0d got=%h want=%h", n, dout8, e_dout[1]); end
      total++; if ({rv8, lm8, sm8} !== {e_rv[1], e_lm[1], e_sm[1]}) begin bad++; $display("FAIL rnd8_flags n=%0d got=%b want=%b", n, {rv8, lm8, sm8}, {e_rv[1], e_lm[1], e_sm[1]}); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word_rw();
    test_extract();
    test_byte_store();
    test_misaligned();
    test_back_to_back();
    test_reset_midload();
    test_lanes8();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
